mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- AW, 32, address width
- DW, 32, data width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- cpu_clk  in  1  single clock; all logic on rising edge
- sys_rstn  in  1  reset, synchronous, active-low
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  CPU write (1) / read (0), stable while cpu_req
- cpu_addr  in  AW  CPU address, stable while cpu_req
- cpu_wdata  in  DW  CPU write data, stable while cpu_req
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data, valid only while cpu_ack
- dbg_ce  in  1  debug access strobe, single-cycle pulse
- dbg_we  in  1  debug write qualifier, sampled with dbg_ce
- dbg_addr  in  AW  debug address, sampled with dbg_ce
- dbg_wdata  in  DW  debug write data, sampled with dbg_ce
- dbg_busy  out  1  debug request pending or in flight
- dbg_rvalid  out  1  one-cycle debug completion pulse
- dbg_rdata  out  DW  registered debug read data, held until next debug read
- dbg_err  out  1  sticky flag: dbg_ce arrived while dbg_busy
- dbg_err_clr  in  1  clears dbg_err
- mem_ce, mem_we  out  1 each  single-port RAM strobes
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_ce

Function
REQ-003 One outstanding access at a time; FSM states IDLE, ISSUE, WAIT.
REQ-004 IDLE: if pend_v, grant debug; else if cpu_req, grant CPU; else stay in IDLE. Grant latches owner, we, addr, wdata into registered mem_* outputs; next state is ISSUE.
REQ-005 ISSUE: mem_ce=1, mem_we=latched we for exactly this cycle. Next state is WAIT.
REQ-006 WAIT: mem_ce=0. Next state is IDLE.
- CPU owner: cpu_ack=1 and cpu_rdata=mem_rdata (combinational).
- Debug owner: dbg_rdata captured from mem_rdata on reads only (writes leave it unchanged); dbg_rvalid pulses next cycle; pend_v clears.
REQ-007 CPU latency: granted at IDLE cycle T, cpu_ack at T+2. Throughput is at most one access per 3 cycles.
REQ-008 cpu_req still high in the IDLE cycle after cpu_ack SHALL be treated as a new request.
REQ-009 Debug pending buffer (one entry: pend_v, we, addr, wdata):
- dbg_ce with dbg_busy=0 loads the buffer; pend_v is high from the next cycle.
- dbg_busy = pend_v | (debug owner in ISSUE/WAIT).
REQ-010 dbg_ce with dbg_busy=1: request dropped; dbg_err set next cycle.
- dbg_err_clr and a set event in the same cycle: set wins.
REQ-011 Debug latency: dbg_ce at cycle N with FSM in IDLE and cpu_req=0 gives mem_ce at N+2 and dbg_rvalid at N+4.
REQ-012 Simultaneous pend_v and cpu_req in IDLE: debug wins; the CPU keeps waiting with its request held.
REQ-013 dbg_ce arriving during a CPU ISSUE/WAIT: buffered, served at the next IDLE ahead of cpu_req.
REQ-014 The CPU cannot starve: debug is limited to one access per dbg_busy window, and every access ends in IDLE where cpu_req is re-evaluated.
REQ-015 mem_we SHALL never be high while mem_ce is low.

Reset
REQ-016 sys_rstn=0 at a rising edge SHALL, at that edge:
- force state IDLE, pend_v=0, owner=CPU
- force mem_ce=0, mem_we=0, cpu_ack=0, dbg_rvalid=0, dbg_err=0
- force mem_addr, mem_wdata, dbg_rdata to 0
REQ-017 Reset mid-access SHALL abort the access with no ack or rvalid. dbg_ce during reset is ignored.

Structure
REQ-018 The FSM state enumeration and owner encoding (CPU=0, DBG=1) belong in a shared package.
REQ-019 The debug pending buffer SHALL be a sub-module, dbg_req_buffer: load, clear, busy and error flag.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- CPU read only: cpu_req, addr 0x10, RAM[0x10]=0xDEADBEEF -> mem_ce at T+1, cpu_ack with cpu_rdata 0xDEADBEEF at T+2.
- Debug write then read: dbg_ce we=1 addr 0x20 data 0x12345678, then dbg_ce we=0 addr 0x20 after dbg_busy falls -> dbg_rvalid twice, dbg_rdata 0x12345678.
- Collision: pend_v and cpu_req high in the same IDLE cycle -> debug access first, cpu_ack 3 cycles later than it would be uncontended.
- Overflow: second dbg_ce while dbg_busy -> dropped, exactly one mem_ce for debug, dbg_err=1 until dbg_err_clr.
- Reset during ISSUE of a CPU write -> no cpu_ack; mem_ce=0 after the edge; after release, a fresh request completes normally.
- Back-to-back CPU reads to 0x0, 0x4 with cpu_req held -> two acks 3 cycles apart, correct data each.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM state codes and access owner.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, debug and RAM signal bundle; master is the arbiter view, slave the client/RAM view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          dbg_ce;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_busy;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_err;
  logic          dbg_err_clr;

  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_ce, dbg_we, dbg_addr, dbg_wdata, dbg_err_clr,
    input  mem_rdata,
    output cpu_ack, cpu_rdata,
    output dbg_busy, dbg_rvalid, dbg_rdata, dbg_err,
    output mem_ce, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_ce, dbg_we, dbg_addr, dbg_wdata, dbg_err_clr,
    output mem_rdata,
    input  cpu_ack, cpu_rdata,
    input  dbg_busy, dbg_rvalid, dbg_rdata, dbg_err,
    input  mem_ce, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_dbg_req_buffer.sv
// One-entry debug request holding register; a strobe while busy is dropped and latches a sticky error.
// Load visible next cycle; entry held until the arbiter clears it at the end of its access.
module dbg_req_buffer #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_wdata,
  input  logic          clear,
  input  logic          inflight,
  input  logic          err_clr,
  output logic          pend_v,
  output logic          pend_we,
  output logic [AW-1:0] pend_addr,
  output logic [DW-1:0] pend_wdata,
  output logic          busy,
  output logic          err
);

  logic accept;
  logic drop;

  assign busy   = pend_v | inflight;
  assign accept = load & ~busy;
  assign drop   = load & busy;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_v     <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      err        <= 1'b0;
    end else begin
      // accept and clear never coincide: clear only happens while busy
      if (accept) begin
        pend_v     <= 1'b1;
        pend_we    <= load_we;
        pend_addr  <= load_addr;
        pend_wdata <= load_wdata;
      end else if (clear) begin
        pend_v <= 1'b0;
      end
      if (drop) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: CPU handshake vs one-deep debug port, one access in flight (IDLE/ISSUE/WAIT).
// Grant to completion is 2 cycles, one access per 3 cycles; a pending debug request wins ties.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic                cpu_clk,
  input logic                sys_rstn,
  mem_port_arbiter_if.master bus
);

  logic [1:0]    state;
  owner_e        owner;
  logic          cur_we;
  logic          mem_ce_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          dbg_rvalid_q;
  logic [DW-1:0] dbg_rdata_q;

  logic          pend_v;
  logic          pend_we;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_wdata;
  logic          buf_busy;
  logic          buf_err;

  logic grant_dbg;
  logic grant_cpu;
  logic dbg_done;
  logic dbg_inflight;

  assign grant_dbg    = (state == ST_IDLE) && pend_v;
  assign grant_cpu    = (state == ST_IDLE) && !pend_v && bus.cpu_req;
  assign dbg_done     = (state == ST_WAIT) && (owner == OWN_DBG);
  assign dbg_inflight = (owner == OWN_DBG) && ((state == ST_ISSUE) || (state == ST_WAIT));

  dbg_req_buffer #(
    .AW(AW),
    .DW(DW)
  ) u_dbg_buf (
    .clk       (cpu_clk),
    .rstn      (sys_rstn),
    .load      (bus.dbg_ce),
    .load_we   (bus.dbg_we),
    .load_addr (bus.dbg_addr),
    .load_wdata(bus.dbg_wdata),
    .clear     (dbg_done),
    .inflight  (dbg_inflight),
    .err_clr   (bus.dbg_err_clr),
    .pend_v    (pend_v),
    .pend_we   (pend_we),
    .pend_addr (pend_addr),
    .pend_wdata(pend_wdata),
    .busy      (buf_busy),
    .err       (buf_err)
  );

  always_ff @(posedge cpu_clk) begin
    if (!sys_rstn) begin
      state        <= ST_IDLE;
      owner        <= OWN_CPU;
      cur_we       <= 1'b0;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      dbg_rvalid_q <= dbg_done;
      case (state)
        ST_IDLE: begin
          if (grant_dbg || grant_cpu) begin
            state       <= ST_ISSUE;
            owner       <= grant_dbg ? OWN_DBG : OWN_CPU;
            cur_we      <= grant_dbg ? pend_we : bus.cpu_we;
            mem_ce_q    <= 1'b1;
            mem_we_q    <= grant_dbg ? pend_we : bus.cpu_we;
            mem_addr_q  <= grant_dbg ? pend_addr : bus.cpu_addr;
            mem_wdata_q <= grant_dbg ? pend_wdata : bus.cpu_wdata;
          end
        end
        ST_ISSUE: begin
          state    <= ST_WAIT;
          mem_ce_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
        default: begin
          // WAIT: RAM data is valid now; debug reads keep it until the next debug read
          state <= ST_IDLE;
          if (dbg_done && !cur_we) begin
            dbg_rdata_q <= bus.mem_rdata;
          end
        end
      endcase
    end
  end

  assign bus.cpu_ack    = (state == ST_WAIT) && (owner == OWN_CPU);
  assign bus.cpu_rdata  = bus.cpu_ack ? bus.mem_rdata : '0;
  assign bus.dbg_busy   = buf_busy;
  assign bus.dbg_err    = buf_err;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.mem_ce     = mem_ce_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule
